// File: rtl/tipi_reg_ctrl_if.sv
// TIPI register controller bus bundle: CPU-side register access,
// readback mux selects/data and the Pi serial register port.
interface tipi_reg_ctrl_if;
  logic        ti_cs;
  logic        ti_memen_n;
  logic        ti_we_n;
  logic [15:0] ti_a;
  logic [7:0]  ti_din;
  logic        sel_rc;
  logic        sel_rd;
  logic        sel_tc;
  logic        sel_td;
  logic [7:0]  rc;
  logic [7:0]  rd;
  logic [7:0]  tc;
  logic [7:0]  td;
  logic        pi_sclk;
  logic        pi_le;
  logic [1:0]  pi_rsel;
  logic        pi_sd_in;
  logic        pi_sd_out;
  logic        pi_commit;
  logic        pi_err;

  modport master (
    output ti_cs, ti_memen_n, ti_we_n, ti_a, ti_din,
    output pi_sclk, pi_le, pi_rsel, pi_sd_in,
    input  sel_rc, sel_rd, sel_tc, sel_td,
    input  rc, rd, tc, td,
    input  pi_sd_out, pi_commit, pi_err
  );

  modport slave (
    input  ti_cs, ti_memen_n, ti_we_n, ti_a, ti_din,
    input  pi_sclk, pi_le, pi_rsel, pi_sd_in,
    output sel_rc, sel_rd, sel_tc, sel_td,
    output rc, rd, tc, td,
    output pi_sd_out, pi_commit, pi_err
  );
endinterface

// File: rtl/tipi_reg_ctrl.sv
// TIPI mailbox register sequencer: CPU decode/write of TC/TD, readback
// selects, and Pi shift/latch FSM committing RD/RC. Ports: clk, reset, bus.
module tipi_reg_ctrl #(
  parameter logic [15:0] BASE_ADDR   = 16'h5FF8,
  parameter int          SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             reset,
  tipi_reg_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    COMMIT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] we_sy;
  logic [SYNC_STAGES-1:0] sclk_sy;
  logic [SYNC_STAGES-1:0] le_sy;
  logic                   we_d;
  logic                   sclk_d;
  logic                   le_d;

  logic [7:0] shreg;
  logic [3:0] bitcnt;
  logic [1:0] rsel;
  logic [7:0] snap;

  logic win_hit;
  logic bus_on;
  logic rd_hit;
  logic we_fall;
  logic sclk_rise;
  logic le_rise;
  logic le_fall;

  assign win_hit = (bus.ti_a[15:3] == BASE_ADDR[15:3]) && bus.ti_a[0];
  assign bus_on  = bus.ti_cs && !bus.ti_memen_n && win_hit;
  assign rd_hit  = bus_on && bus.ti_we_n;

  assign we_fall   = we_d & ~we_sy[SYNC_STAGES-1];
  assign sclk_rise = sclk_sy[SYNC_STAGES-1] & ~sclk_d;
  assign le_rise   = le_sy[SYNC_STAGES-1] & ~le_d;
  assign le_fall   = le_d & ~le_sy[SYNC_STAGES-1];

  // rsel[0] picks TC over TD for Pi reads
  assign snap = bus.pi_rsel[0] ? bus.tc : bus.td;

  always_ff @(posedge clk) begin
    if (reset) begin
      we_sy   <= '1;
      sclk_sy <= '0;
      le_sy   <= '0;
      we_d    <= 1'b1;
      sclk_d  <= 1'b0;
      le_d    <= 1'b0;
    end else begin
      we_sy   <= {we_sy[SYNC_STAGES-2:0], bus.ti_we_n};
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], bus.pi_sclk};
      le_sy   <= {le_sy[SYNC_STAGES-2:0], bus.pi_le};
      we_d    <= we_sy[SYNC_STAGES-1];
      sclk_d  <= sclk_sy[SYNC_STAGES-1];
      le_d    <= le_sy[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (le_rise) state_nxt = ACTIVE;
      ACTIVE:  if (le_fall) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sel_rc    <= 1'b0;
      bus.sel_rd    <= 1'b0;
      bus.sel_tc    <= 1'b0;
      bus.sel_td    <= 1'b0;
      bus.rc        <= '0;
      bus.rd        <= '0;
      bus.tc        <= '0;
      bus.td        <= '0;
      bus.pi_sd_out <= 1'b0;
      bus.pi_commit <= 1'b0;
      bus.pi_err    <= 1'b0;
      shreg         <= '0;
      bitcnt        <= '0;
      rsel          <= '0;
    end else begin
      bus.pi_commit <= 1'b0;
      bus.pi_err    <= 1'b0;
      bus.sel_rc    <= rd_hit && (bus.ti_a[2:1] == 2'b00);
      bus.sel_rd    <= rd_hit && (bus.ti_a[2:1] == 2'b01);
      bus.sel_tc    <= rd_hit && (bus.ti_a[2:1] == 2'b10);
      bus.sel_td    <= rd_hit && (bus.ti_a[2:1] == 2'b11);

      // RC/RD are Pi-owned; CPU writes to them fall through
      if (we_fall && bus_on) begin
        if (bus.ti_a[2:1] == 2'b10) bus.tc <= bus.ti_din;
        if (bus.ti_a[2:1] == 2'b11) bus.td <= bus.ti_din;
      end

      unique case (state)
        IDLE: begin
          if (le_rise) begin
            rsel   <= bus.pi_rsel;
            bitcnt <= '0;
            if (!bus.pi_rsel[1]) begin
              // non-blocking read gives the pre-write value
              shreg         <= snap;
              bus.pi_sd_out <= snap[7];
            end else begin
              shreg <= '0;
            end
          end
        end
        ACTIVE: begin
          if (sclk_rise) begin
            shreg         <= {shreg[6:0], bus.pi_sd_in};
            bus.pi_sd_out <= shreg[6];
            if (bitcnt != 4'd9) bitcnt <= bitcnt + 4'd1;
          end
        end
        COMMIT: begin
          bus.pi_sd_out <= 1'b0;
          if (bitcnt != 4'd8) begin
            bus.pi_err <= 1'b1;
          end else if (rsel[1]) begin
            bus.pi_commit <= 1'b1;
            if (rsel[0]) bus.rc <= shreg;
            else         bus.rd <= shreg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tipi_reg_ctrl.sv
// Self-checking bench for tipi_reg_ctrl: CPU register access, Pi
// transactions, reset abort and write/snapshot collision.
module tb_tipi_reg_ctrl;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  typedef struct packed {
    logic [1:0] code;
    logic [1:0] rs;
    logic [7:0] val;
  } pi_evt_t;

  pi_evt_t exp_q[$];

  tipi_reg_ctrl_if bus ();

  tipi_reg_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] sels();
    return {bus.sel_rc, bus.sel_rd, bus.sel_tc, bus.sel_td};
  endfunction

  // Pi-side pulse monitor: every pulse must match the next expected event
  always @(negedge clk) begin
    if (!reset && (bus.pi_commit || bus.pi_err)) begin
      if (exp_q.size() == 0) begin
        chk("pi_evt_unexp", {14'd0, bus.pi_err, bus.pi_commit}, 16'd0);
      end else begin
        pi_evt_t e;
        e = exp_q.pop_front();
        chk("pi_evt", {14'd0, bus.pi_err, bus.pi_commit}, {14'd0, e.code});
        if (e.code == 2'b01)
          chk("pi_data", {8'd0, e.rs[0] ? bus.rc : bus.rd}, {8'd0, e.val});
      end
    end
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.ti_cs = 1'b1;
    bus.ti_a = a;
    bus.ti_din = d;
    bus.ti_memen_n = 1'b0;
    bus.ti_we_n = 1'b0;
    cyc(5);
    bus.ti_we_n = 1'b1;
    cyc(2);
    bus.ti_memen_n = 1'b1;
    cyc(5);
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [3:0] exp);
    bus.ti_cs = 1'b1;
    bus.ti_a = a;
    bus.ti_we_n = 1'b1;
    bus.ti_memen_n = 1'b0;
    cyc(1);
    chk("sel_rd", {12'd0, sels()}, {12'd0, exp});
    bus.ti_memen_n = 1'b1;
    cyc(1);
    chk("sel_idle", {12'd0, sels()}, 16'd0);
  endtask

  // code: 00 none, 01 commit (val lands in rs target), 10 err
  task automatic pi_xfer(input logic [1:0] rs, input logic [7:0] data,
                         input int nbits, input logic chk_out,
                         input logic [7:0] exp_out, input logic [1:0] code,
                         input logic do_wr, input logic [7:0] wr_d);
    if (code != 2'b00) exp_q.push_back({code, rs, data});
    bus.pi_rsel = rs;
    bus.pi_le = 1'b1;
    if (do_wr) begin
      bus.ti_cs = 1'b1;
      bus.ti_a = 16'h5FFF;
      bus.ti_din = wr_d;
      bus.ti_memen_n = 1'b0;
      bus.ti_we_n = 1'b0;
    end
    cyc(5);
    bus.ti_we_n = 1'b1;
    bus.ti_memen_n = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      bus.pi_sd_in = (i < 8) ? data[7-i] : 1'b0;
      if (chk_out && i < 8)
        chk("sd_out_bit", {15'd0, bus.pi_sd_out}, {15'd0, exp_out[7-i]});
      bus.pi_sclk = 1'b1;
      cyc(5);
      bus.pi_sclk = 1'b0;
      cyc(5);
    end
    bus.pi_le = 1'b0;
    cyc(8);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"}, {12'd0, sels()}, 16'd0);
    chk({tag, "_rcrd"}, {bus.rc, bus.rd}, 16'd0);
    chk({tag, "_tctd"}, {bus.tc, bus.td}, 16'd0);
    chk({tag, "_pi"}, {13'd0, bus.pi_sd_out, bus.pi_commit, bus.pi_err},
        16'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.ti_cs = 1'b0;
    bus.ti_memen_n = 1'b1;
    bus.ti_we_n = 1'b1;
    bus.ti_a = 16'h0000;
    bus.ti_din = 8'h00;
    bus.pi_sclk = 1'b0;
    bus.pi_le = 1'b0;
    bus.pi_rsel = 2'b00;
    bus.pi_sd_in = 1'b0;
    cyc(4);
    reset = 1'b0;
    cyc(2);
    chk_all_zero("reset");

    // CPU write/read TD, RD write ignored
    cpu_write(16'h5FFF, 8'hA5);
    chk("td_wr", {8'd0, bus.td}, 16'h00A5);
    cpu_read(16'h5FFF, 4'b0001);
    cpu_write(16'h5FFB, 8'h77);
    chk("rd_cpu_wr_ignored", {8'd0, bus.rd}, 16'h0000);
    cpu_write(16'h4FFD, 8'h66);
    chk("tc_miss", {8'd0, bus.tc}, 16'h0000);

    // reset in the middle of a TD read
    bus.pi_rsel = 2'b00;
    bus.pi_le = 1'b1;
    cyc(5);
    for (int i = 0; i < 3; i++) begin
      bus.pi_sclk = 1'b1;
      cyc(5);
      bus.pi_sclk = 1'b0;
      cyc(5);
    end
    chk("mid_sd_out", {15'd0, bus.pi_sd_out}, 16'd0);
    reset = 1'b1;
    bus.pi_le = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk_all_zero("abort");
    cyc(8);

    // Pi write RC = 0x3C
    pi_xfer(2'b11, 8'h3C, 8, 1'b0, 8'h00, 2'b01, 1'b0, 8'h00);
    chk("rc_val", {8'd0, bus.rc}, 16'h003C);
    cpu_read(16'h5FF9, 4'b1000);

    // Pi read TC = 0x81
    cpu_write(16'h5FFD, 8'h81);
    pi_xfer(2'b01, 8'h00, 8, 1'b1, 8'h81, 2'b00, 1'b0, 8'h00);
    chk("tc_keep", {8'd0, bus.tc}, 16'h0081);

    // RD: good write, then short and long transfers
    pi_xfer(2'b10, 8'h5A, 8, 1'b0, 8'h00, 2'b01, 1'b0, 8'h00);
    chk("rd_val", {8'd0, bus.rd}, 16'h005A);
    pi_xfer(2'b10, 8'hC3, 7, 1'b0, 8'h00, 2'b10, 1'b0, 8'h00);
    chk("rd_short", {8'd0, bus.rd}, 16'h005A);
    pi_xfer(2'b10, 8'hC3, 10, 1'b0, 8'h00, 2'b10, 1'b0, 8'h00);
    chk("rd_long", {8'd0, bus.rd}, 16'h005A);

    // CPU TD write collides with le rise: snapshot is old value
    cpu_write(16'h5FFF, 8'h11);
    pi_xfer(2'b00, 8'h00, 8, 1'b1, 8'h11, 2'b00, 1'b1, 8'h55);
    chk("td_new", {8'd0, bus.td}, 16'h0055);
    pi_xfer(2'b00, 8'h00, 8, 1'b1, 8'h55, 2'b00, 1'b0, 8'h00);

    cyc(10);
    chk("sb_empty", exp_q.size(), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
